// File: rtl/lsu_dmem_master_pkg.sv
// Shared definitions for the MEM-stage data-RAM load/store initiator.
// Holds the access size codes, the FSM state encoding, the default RAM
// index width and small helpers for alignment decisions.
package lsu_dmem_master_pkg;

   localparam int unsigned IDX_W_DEF = 5;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;  // 2'b11 is also treated as a word

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StAcc   = 3'd1,
      StRmwRd = 3'd2,
      StRmwWr = 3'd3,
      StDone  = 3'd4
   } lsu_state_e;

   function automatic logic is_subword(input logic [1:0] size);
      return (size == SZ_B) || (size == SZ_H);
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      if (size == SZ_B) return 1'b0;
      if (size == SZ_H) return off[0];
      return off != 2'b00;
   endfunction

   // Byte offset forced to the natural alignment of the access size.
   function automatic logic [1:0] natural_off(input logic [1:0] size, input logic [1:0] off);
      if (size == SZ_B) return off;
      if (size == SZ_H) return {off[1], 1'b0};
      return 2'b00;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational little-endian lane logic for the data-RAM initiator.
//   size_i  : access size code (SZ_B/SZ_H/SZ_W, 11 = word)
//   sext_i  : sign-extend sub-word loads
//   off_i   : byte offset within the word (already aligned to the size)
//   word_i  : RAM word being read or merged into
//   wdata_i : right-justified store data
//   load_o  : selected lane, zero/sign extended to 32 bits
//   merge_o : word_i with the addressed lane(s) replaced by wdata_i
module lsu_lane_align
   import lsu_dmem_master_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        sext_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [31:0] mask;
   logic [31:0] wdata_sh;

   // A half always has off_i[0] = 0, so one byte-granular shift serves both sizes.
   assign shamt    = {off_i, 3'b000};
   assign shifted  = word_i >> shamt;
   assign wdata_sh = wdata_i << shamt;

   always_comb begin
      load_o = word_i;
      mask   = 32'hFFFF_FFFF;
      case (size_i)
         SZ_B: begin
            load_o = {{24{sext_i & shifted[7]}}, shifted[7:0]};
            mask   = 32'h0000_00FF << shamt;
         end
         SZ_H: begin
            load_o = {{16{sext_i & shifted[15]}}, shifted[15:0]};
            mask   = 32'h0000_FFFF << shamt;
         end
         default: begin
            load_o = word_i;
            mask   = 32'hFFFF_FFFF;
         end
      endcase
   end

   assign merge_o = (word_i & ~mask) | (wdata_sh & mask);

endmodule

// File: rtl/lsu_dmem_master.sv
// MEM-stage load/store initiator for a word-only, single-port data RAM
// (asynchronous read, synchronous write). Byte/half/word pipeline accesses
// become word-aligned RAM accesses; sub-word stores use read-modify-write.
//
// Ports:
//   clk_i, clrn_i        clock, asynchronous active-low reset
//   req_i                request, held stable until done_o
//   we_i, size_i, sext_i store flag, size code, load sign-extend
//   addr_i, wdata_i      byte address, right-justified store data
//   rdata_o, done_o      load result, one-cycle completion pulse
//   err_o                misaligned-access pulse (with done_o)
//   stall_o              req_i & ~done_o
//   ram_we_o, ram_addr_o, ram_din_o, ram_dout_i   RAM port
//
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned accesses
// through err_o without touching the RAM. Without it the address low bits
// are forced to the natural alignment and err_o is tied low.
module lsu_dmem_master
   import lsu_dmem_master_pkg::*;
#(
   parameter int unsigned IDX_W = IDX_W_DEF,
   parameter int unsigned AW    = 32
) (
   input  logic          clk_i,
   input  logic          clrn_i,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [1:0]    size_i,
   input  logic          sext_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o,
   output logic          done_o,
   output logic          err_o,
   output logic          stall_o,
   output logic          ram_we_o,
   output logic [AW-1:0] ram_addr_o,
   output logic [31:0]   ram_din_o,
   input  logic [31:0]   ram_dout_i
);

   lsu_state_e       state_q;
   logic             we_q;
   logic [1:0]       size_q;
   logic             sext_q;
   logic [1:0]       off_q;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      wdata_q;
   logic [31:0]      merge_q;
   logic [31:0]      rdata_q;
   logic             done_q;
`ifdef LSU_MISALIGN_TRAP_EN
   logic             err_q;
`endif

   logic [31:0] lane_word;
   logic [31:0] lane_load;
   logic [31:0] lane_merge;

   // Address bits above the RAM index never reach the RAM.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_i[AW-1:IDX_W+2];

   // ACC extracts from the live RAM word; RMW_WR merges into the captured one.
   assign lane_word = (state_q == StAcc) ? ram_dout_i : merge_q;

   lsu_lane_align u_lane_align (
      .size_i  (size_q),
      .sext_i  (sext_q),
      .off_i   (off_q),
      .word_i  (lane_word),
      .wdata_i (wdata_q),
      .load_o  (lane_load),
      .merge_o (lane_merge)
   );

   always_ff @(posedge clk_i or negedge clrn_i) begin
      if (!clrn_i) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         off_q   <= 2'b00;
         idx_q   <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (req_i) begin
                  we_q    <= we_i;
                  size_q  <= size_i;
                  sext_q  <= sext_i;
                  wdata_q <= wdata_i;
                  idx_q   <= addr_i[IDX_W+1:2];
`ifdef LSU_MISALIGN_TRAP_EN
                  off_q   <= addr_i[1:0];
                  if (is_misaligned(size_i, addr_i[1:0])) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (we_i && is_subword(size_i)) begin
                     state_q <= StRmwRd;
                  end else begin
                     state_q <= StAcc;
                  end
`else
                  off_q   <= natural_off(size_i, addr_i[1:0]);
                  if (we_i && is_subword(size_i)) begin
                     state_q <= StRmwRd;
                  end else begin
                     state_q <= StAcc;
                  end
`endif
               end
            end
            StAcc: begin
               if (!we_q) begin
                  rdata_q <= lane_load;
               end
               state_q <= StDone;
               done_q  <= 1'b1;
            end
            StRmwRd: begin
               merge_q <= ram_dout_i;
               state_q <= StRmwWr;
            end
            StRmwWr: begin
               state_q <= StDone;
               done_q  <= 1'b1;
            end
            StDone: begin
               done_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
               err_q   <= 1'b0;
`endif
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Write strobe decoded from state so an asynchronous reset kills it at once.
   // A store in ACC is always a word store; sub-words go through RMW.
   assign ram_we_o = ((state_q == StAcc) && we_q) || (state_q == StRmwWr);

   always_comb begin
      ram_din_o = '0;
      if ((state_q == StAcc) && we_q) begin
         ram_din_o = wdata_q;
      end else if (state_q == StRmwWr) begin
         ram_din_o = lane_merge;
      end
   end

   always_comb begin
      ram_addr_o = '0;
      ram_addr_o[IDX_W+1:2] = idx_q;
   end

   assign rdata_o = rdata_q;
   assign done_o  = done_q;
   assign stall_o = req_i & ~done_q;
`ifdef LSU_MISALIGN_TRAP_EN
   assign err_o   = err_q;
`else
   assign err_o   = 1'b0;
`endif

endmodule
